// File: rtl/patdet_prog.sv
// rtl/patdet_prog.sv - programmable serial pattern detector with optional match counter
// Optional feature macro: PATDET_PROG_COUNT_EN (saturating match counter on match_cnt_o)
module patdet_prog #(
   parameter int               PAT_W   = 8,
   parameter int               CNT_W   = 16,
   parameter logic [PAT_W-1:0] PAT_RST = 8'h1B,
   parameter int               LEN_RST = 5,
   localparam int              LW      = $clog2(PAT_W + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             din,
   input  logic             valid_i,
   input  logic             mode_ovl_i,
   input  logic             cfg_load_i,
   input  logic [PAT_W-1:0] pat_i,
   input  logic [LW-1:0]    len_i,
   output logic             pat_det_o,
   output logic [CNT_W-1:0] match_cnt_o
);

   // The oldest history bit shifts out before it could ever be compared, so it is not stored.
   logic [PAT_W-2:0] hist;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] shifted;
   logic [PAT_W-1:0] mask;
   logic [LW-1:0]    fill;
   logic [LW-1:0]    len_q;
   logic [LW-1:0]    len_clamped;
   logic [LW-1:0]    fill_next;
   logic [LW:0]      fill_inc;
   logic             hit;

   always_comb begin
      shifted  = {hist, din};
      fill_inc = {1'b0, fill} + (LW+1)'(1);
      mask     = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (i < int'(len_q));
      end
      hit = valid_i && !cfg_load_i &&
            (fill_inc >= {1'b0, len_q}) &&
            (((shifted ^ pat_q) & mask) == '0);
      if (hit && !mode_ovl_i) begin
         fill_next = '0;
      end else if (fill_inc > (LW+1)'(PAT_W)) begin
         fill_next = LW'(PAT_W);
      end else begin
         fill_next = fill_inc[LW-1:0];
      end
      len_clamped = ((len_i == '0) || (len_i > LW'(PAT_W))) ? LW'(PAT_W) : len_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hist      <= '0;
         fill      <= '0;
         pat_q     <= PAT_RST;
         len_q     <= LW'(LEN_RST);
         pat_det_o <= 1'b0;
      end else begin
         pat_det_o <= hit;
         if (cfg_load_i) begin
            pat_q <= pat_i;
            len_q <= len_clamped;
            fill  <= '0;
            hist  <= '0;
         end else if (valid_i) begin
            hist <= shifted[PAT_W-2:0];
            fill <= fill_next;
         end
      end
   end

`ifdef PATDET_PROG_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (cfg_load_i) begin
         cnt_q <= '0;
      end else if (hit && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign match_cnt_o = cnt_q;
`else
   assign match_cnt_o = '0;
`endif

endmodule

// File: tb/tb_patdet_prog.sv
// tb/tb_patdet_prog.sv - randomized and directed bench for patdet_prog against a bit-queue model
module tb_patdet_prog;

`ifdef PATDET_PROG_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       din = 1'b0;
   logic       valid_i = 1'b0;
   logic       mode_ovl_i = 1'b1;
   logic       cfg_load_i = 1'b0;
   logic [7:0] pat_i = '0;
   logic [3:0] len_i = '0;
   logic       det_a, det_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   int checks = 0;
   int passes = 0;

   // Model: consumed bits since the last clear, newest at the back.
   bit         mq[$];
   logic [7:0] m_pat;
   int         m_len;
   int         m_cnt;
   bit         exp_det;

   patdet_prog dut_a (
      .clk_i(clk), .rst_ni(rst_ni), .din(din), .valid_i(valid_i),
      .mode_ovl_i(mode_ovl_i), .cfg_load_i(cfg_load_i), .pat_i(pat_i),
      .len_i(len_i), .pat_det_o(det_a), .match_cnt_o(cnt_a)
   );

   patdet_prog #(.CNT_W(2)) dut_b (
      .clk_i(clk), .rst_ni(rst_ni), .din(din), .valid_i(valid_i),
      .mode_ovl_i(mode_ovl_i), .cfg_load_i(cfg_load_i), .pat_i(pat_i),
      .len_i(len_i), .pat_det_o(det_b), .match_cnt_o(cnt_b)
   );

   always #5 clk = ~clk;

   function automatic int clamp_len(input logic [3:0] l);
      return (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
   endfunction

   function automatic logic [15:0] exp_cnt_a();
      return CNT_EN ? 16'((m_cnt > 65535) ? 65535 : m_cnt) : 16'd0;
   endfunction

   function automatic logic [1:0] exp_cnt_b();
      return CNT_EN ? 2'((m_cnt > 3) ? 3 : m_cnt) : 2'd0;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pat   = 8'h1B;
      m_len   = 5;
      m_cnt   = 0;
      exp_det = 1'b0;
   endtask

   task automatic do_reset();
      valid_i    = 1'b0;
      cfg_load_i = 1'b0;
      rst_ni     = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic drive(input bit v, input bit d, input bit ovl, input bit ld,
                        input logic [7:0] p, input logic [3:0] l);
      bit hit;
      valid_i    = v;
      din        = d;
      mode_ovl_i = ovl;
      cfg_load_i = ld;
      pat_i      = p;
      len_i      = l;
      @(posedge clk);
      exp_det = 1'b0;
      if (ld) begin
         m_pat = p;
         m_len = clamp_len(l);
         mq.delete();
         m_cnt = 0;
      end else if (v) begin
         mq.push_back(d);
         if (mq.size() > 40) void'(mq.pop_front());
         hit = (mq.size() >= m_len);
         if (hit) begin
            for (int i = 0; i < m_len; i++) begin
               if (mq[mq.size()-1-i] != m_pat[i]) hit = 1'b0;
            end
         end
         if (hit) begin
            exp_det = 1'b1;
            m_cnt++;
            if (!ovl) mq.delete();
         end
      end
      #1;
      valid_i    = 1'b0;
      cfg_load_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({det_a, det_b, cnt_a, cnt_b} !== 20'd0)
         $display("FAIL reset: det=%b/%b cnt=%0d/%0d expected all 0", det_a, det_b, cnt_a, cnt_b);
      else passes++;
      rst_ni = 1'b1;
      model_reset();
   endtask

   task automatic test_overlap();
      logic [7:0] seq;
      seq = 8'b11011011;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, seq[7-i], 1'b1, 1'b0, 8'h00, 4'd0);
         checks++;
         if (det_a !== (i == 4 || i == 7) || det_b !== exp_det || cnt_a !== exp_cnt_a())
            $display("FAIL overlap bit%0d: det=%b/%b cnt=%0d expected det=%b cnt=%0d",
                     i, det_a, det_b, cnt_a, exp_det, exp_cnt_a());
         else passes++;
      end
      checks++;
      if (cnt_a !== (CNT_EN ? 16'd2 : 16'd0))
         $display("FAIL overlap_count: cnt=%0d expected %0d", cnt_a, CNT_EN ? 2 : 0);
      else passes++;
   endtask

   task automatic test_non_overlap();
      logic [7:0] seq;
      seq = 8'b11011011;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, seq[7-i], 1'b0, 1'b0, 8'h00, 4'd0);
         checks++;
         if (det_a !== (i == 4) || det_b !== exp_det || cnt_b !== exp_cnt_b())
            $display("FAIL nonovl bit%0d: det=%b/%b cnt=%0d expected det=%b cnt=%0d",
                     i, det_a, det_b, cnt_b, exp_det, exp_cnt_b());
         else passes++;
      end
      checks++;
      if (cnt_a !== (CNT_EN ? 16'd1 : 16'd0))
         $display("FAIL nonovl_count: cnt=%0d expected %0d", cnt_a, CNT_EN ? 1 : 0);
      else passes++;
   endtask

   task automatic test_gaps();
      logic [7:0] seq;
      seq = 8'b11011011;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, seq[7-i], 1'b1, 1'b0, 8'h00, 4'd0);
         checks++;
         if (det_a !== (i == 4 || i == 7) || det_b !== exp_det)
            $display("FAIL gaps bit%0d: det=%b/%b expected %b", i, det_a, det_b, exp_det);
         else passes++;
         drive(1'b0, 1'($urandom), 1'b1, 1'b0, 8'h00, 4'd0);
         checks++;
         if (det_a !== 1'b0 || cnt_a !== exp_cnt_a())
            $display("FAIL gaps idle%0d: det=%b cnt=%0d expected det=0 cnt=%0d",
                     i, det_a, cnt_a, exp_cnt_a());
         else passes++;
      end
   endtask

   task automatic test_load_short();
      logic [4:0] seq;
      seq = 5'b10101;
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 4'd3);
      checks++;
      if (det_a !== 1'b0 || cnt_a !== 16'd0)
         $display("FAIL load_cycle: det=%b cnt=%0d expected det=0 cnt=0", det_a, cnt_a);
      else passes++;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, seq[4-i], 1'b1, 1'b0, 8'h00, 4'd0);
         checks++;
         if (det_a !== (i == 2 || i == 4) || det_b !== exp_det || cnt_a !== exp_cnt_a())
            $display("FAIL load_short bit%0d: det=%b/%b cnt=%0d expected det=%b cnt=%0d",
                     i, det_a, det_b, cnt_a, exp_det, exp_cnt_a());
         else passes++;
      end
   endtask

   task automatic test_len0_reset();
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
         checks++;
         if (det_a !== (i == 7) || det_b !== exp_det)
            $display("FAIL len0 bit%0d: det=%b/%b expected %b", i, det_a, det_b, exp_det);
         else passes++;
      end
      // Pulse is high right now; reset must drop it without waiting for a clock edge.
      rst_ni = 1'b0;
      #1;
      checks++;
      if (det_a !== 1'b0 || cnt_a !== 16'd0 || cnt_b !== 2'd0)
         $display("FAIL async_reset: det=%b cnt=%0d/%0d expected 0", det_a, cnt_a, cnt_b);
      else passes++;
      model_reset();
      rst_ni = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 4'd0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 4'd0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
         checks++;
         if (det_a !== (i == 7) || det_b !== exp_det)
            $display("FAIL len0_after_reset bit%0d: det=%b/%b expected %b",
                     i, det_a, det_b, exp_det);
         else passes++;
      end
   endtask

   task automatic test_saturate();
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'd1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
         checks++;
         if (det_a !== 1'b1 || cnt_b !== exp_cnt_b() || cnt_a !== exp_cnt_a())
            $display("FAIL saturate bit%0d: det=%b cnt=%0d/%0d expected det=1 cnt=%0d/%0d",
                     i, det_a, cnt_a, cnt_b, exp_cnt_a(), exp_cnt_b());
         else passes++;
      end
      checks++;
      if (cnt_b !== (CNT_EN ? 2'd3 : 2'd0) || cnt_a !== (CNT_EN ? 16'd5 : 16'd0))
         $display("FAIL saturate_final: cnt=%0d/%0d expected %0d/%0d",
                  cnt_a, cnt_b, CNT_EN ? 5 : 0, CNT_EN ? 3 : 0);
      else passes++;
   endtask

   task automatic test_random();
      bit         v, ld, ovl;
      logic [3:0] l;
      do_reset();
      ovl = 1'b1;
      for (int i = 0; i < 800; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         ld = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 15) == 0) ovl = ~ovl;
         l  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
         drive(v, 1'($urandom), ovl, ld, 8'($urandom), l);
         checks++;
         if (det_a !== exp_det || det_b !== exp_det ||
             cnt_a !== exp_cnt_a() || cnt_b !== exp_cnt_b())
            $display("FAIL random cyc%0d: det=%b/%b cnt=%0d/%0d expected det=%b cnt=%0d/%0d",
                     i, det_a, det_b, cnt_a, cnt_b, exp_det, exp_cnt_a(), exp_cnt_b());
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_non_overlap();
      test_gaps();
      test_load_short();
      test_len0_reset();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
